// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The optional FETCH_PERF_EN macro (see fetch_unit) adds performance counters.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched (pc, instr) pairs; flush dominates push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed while count covers them.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order imem requests, response queue, redirect squash.
// Define FETCH_PERF_EN to add the perf_fetched / perf_discarded counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
`endif
);

  localparam int          CW        = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic [31:0]   fetch_addr;
  logic [31:0]   resp_addr;
  logic [31:0]   target_addr;
  logic          grant;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // Credit counts every response still owed, so the queue always has room for it.
  assign credit_used      = {1'b0, outstanding} + {1'b0, count};
  assign imem_req         = reset_n && !redirect_valid && (credit_used < DEPTH_LIM);
  assign imem_addr        = fetch_addr;
  assign grant            = imem_req && imem_gnt;
  assign outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid);
  assign target_addr      = {redirect_addr[31:2], 2'b00};

  assign push       = imem_rvalid && (state == FETCH) && !redirect_valid;
  assign pop        = id_valid && id_ready && !redirect_valid;
  assign push_entry = '{pc: resp_addr, instr: imem_rdata};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = (outstanding_next != '0) ? FLUSH : FETCH;
    end else if ((state == FLUSH) && imem_rvalid && (discard_cnt == CW'(1))) begin
      state_next = FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      outstanding <= '0;
      discard_cnt <= '0;
      fetch_addr  <= RESET_PC;
      resp_addr   <= RESET_PC;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_addr  <= target_addr;
        resp_addr   <= target_addr;
        discard_cnt <= outstanding_next;
      end else begin
        if (grant) fetch_addr <= fetch_addr + 32'd4;
        if (push)  resp_addr  <= resp_addr + 32'd4;
        if ((state == FLUSH) && imem_rvalid) discard_cnt <= discard_cnt - CW'(1);
      end
    end
  end

  assign id_valid    = (count != '0);
  assign id_instr    = id_valid ? head.instr : NOP_INSTR;
  assign id_pc       = id_valid ? head.pc : 32'd0;
  assign id_pc_plus4 = id_pc + 32'd4;

`ifdef FETCH_PERF_EN
  // A redirect discards both the dropped response and everything still queued.
  logic squashed;
  assign squashed = imem_rvalid && ((state == FLUSH) || redirect_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      perf_fetched   <= perf_fetched + 32'(pop);
      perf_discarded <= perf_discarded + 32'(squashed)
                        + (redirect_valid ? 32'(count) : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order memory responder.
// Perf counter checks are compiled in only when FETCH_PERF_EN is defined.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] pend[$];
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_instr;
  logic [31:0] s_plus4;
  logic [31:0] s_pfetch;
  logic [31:0] s_pdisc;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // One bus cycle: drive at the falling edge, sample 1ns later, log grants.
  task automatic cycle(input logic redir, input logic [31:0] raddr, input logic ready,
                       input logic gnt, input logic hold);
    @(negedge clk);
    reset_n        = 1'b1;
    redirect_valid = redir;
    redirect_addr  = raddr;
    id_ready       = ready;
    imem_gnt       = gnt;
    if (!hold && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = id_valid;
    s_pc    = id_pc;
    s_instr = id_instr;
    s_plus4 = id_pc_plus4;
`ifdef FETCH_PERF_EN
    s_pfetch = perf_fetched;
    s_pdisc  = perf_discarded;
`else
    s_pfetch = '0;
    s_pdisc  = '0;
`endif
    if (imem_req && imem_gnt) pend.push_back(imem_addr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    id_ready       = 1'b0;
    pend.delete();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_req got req=%b addr=%h want req=0 addr=00000000", imem_req, imem_addr);
    end
    checks++;
    if (id_valid !== 1'b0 || id_instr !== 32'h13) begin
      failures++;
      $display("FAIL reset_id got valid=%b instr=%h want valid=0 instr=00000013", id_valid, id_instr);
    end
    checks++;
    if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin
      failures++;
      $display("FAIL reset_pc got pc=%h plus4=%h want pc=00000000 plus4=00000004", id_pc, id_pc_plus4);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'(4 * k)) begin
        failures++;
        $display("FAIL stream_req k=%0d got req=%b addr=%h want req=1 addr=%h", k, s_req, s_addr, 32'(4 * k));
      end
      checks++;
      if (k < 2) begin
        if (s_valid !== 1'b0) begin
          failures++;
          $display("FAIL stream_early k=%0d got valid=%b want 0", k, s_valid);
        end
      end else begin
        exp_pc = 32'(4 * (k - 2));
        if (s_valid !== 1'b1 || s_pc !== exp_pc || s_instr !== mem_word(exp_pc) || s_plus4 !== exp_pc + 32'd4) begin
          failures++;
          $display("FAIL stream_id k=%0d got valid=%b pc=%h instr=%h plus4=%h want pc=%h instr=%h",
                   k, s_valid, s_pc, s_instr, s_plus4, exp_pc, mem_word(exp_pc));
        end
      end
    end
  endtask

  task automatic test_stall();
    int grants = 0;
    int pops = 0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      if (s_req) grants++;
    end
    checks++;
    if (grants != DEPTH || s_req !== 1'b0) begin
      failures++;
      $display("FAIL stall_credit got grants=%0d req=%b want grants=%0d req=0", grants, s_req, DEPTH);
    end
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0) begin
      failures++;
      $display("FAIL stall_head got valid=%b pc=%h want valid=1 pc=00000000", s_valid, s_pc);
    end
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (s_valid) begin
        checks++;
        if (s_pc !== 32'(4 * pops) || s_instr !== mem_word(32'(4 * pops))) begin
          failures++;
          $display("FAIL drain_order got pc=%h instr=%h want pc=%h", s_pc, s_instr, 32'(4 * pops));
        end
        pops++;
      end
    end
    checks++;
    if (pops != 12) begin
      failures++;
      $display("FAIL drain_rate got pops=%0d want 12", pops);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
    checks++;
    if (s_req !== 1'b0) begin
      failures++;
      $display("FAIL redir_req got req=%b want 0", s_req);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (s_valid !== 1'b0 || (k == 0 && s_addr !== 32'h100)) begin
        failures++;
        $display("FAIL redir_squash k=%0d got valid=%b addr=%h want valid=0 addr=00000100", k, s_valid, s_addr);
      end
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_instr !== mem_word(32'h100)) begin
      failures++;
      $display("FAIL redir_target got valid=%b pc=%h instr=%h want pc=00000100", s_valid, s_pc, s_instr);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (s_pdisc !== 32'd2 || s_pfetch !== 32'd0) begin
      failures++;
      $display("FAIL redir_perf got disc=%0d fetched=%0d want disc=2 fetched=0", s_pdisc, s_pfetch);
    end
`endif
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h104) begin
      failures++;
      $display("FAIL redir_next got valid=%b pc=%h want pc=00000104", s_valid, s_pc);
    end
  endtask

  task automatic test_redirect_overlap();
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h203, 1'b1, 1'b1, 1'b0);
    checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'hC) begin
      failures++;
      $display("FAIL overlap_cycle got req=%b valid=%b pc=%h want req=0 valid=1 pc=0000000c", s_req, s_valid, s_pc);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h200 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL overlap_align got req=%b addr=%h valid=%b want req=1 addr=00000200 valid=0", s_req, s_addr, s_valid);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL overlap_dup got valid=%b pc=%h want valid=0", s_valid, s_pc);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h200 || s_plus4 !== 32'h204) begin
      failures++;
      $display("FAIL overlap_target got valid=%b pc=%h plus4=%h want pc=00000200 plus4=00000204", s_valid, s_pc, s_plus4);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (s_pdisc !== 32'd2 || s_pfetch !== 32'd3) begin
      failures++;
      $display("FAIL overlap_perf got disc=%0d fetched=%0d want disc=2 fetched=3", s_pdisc, s_pfetch);
    end
`endif
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h204) begin
      failures++;
      $display("FAIL overlap_next got valid=%b pc=%h want pc=00000204", s_valid, s_pc);
    end
  endtask

  task automatic test_no_grant();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin
        failures++;
        $display("FAIL nognt_hold k=%0d got req=%b addr=%h valid=%b want req=1 addr=00000000 valid=0",
                 k, s_req, s_addr, s_valid);
      end
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (s_addr !== 32'h4 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL nognt_resume got addr=%h valid=%b want addr=00000004 valid=0", s_addr, s_valid);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0) begin
      failures++;
      $display("FAIL nognt_first got valid=%b pc=%h want valid=1 pc=00000000", s_valid, s_pc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_overlap();
    test_no_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the program counter. It owns the fetch address, issues in-order requests to instruction memory over a request/grant/response bus, buffers returned words in a small queue, and hands (pc, instruction) pairs to decode over a valid/ready handshake. Redirects for jumps and taken branches flush the queue and squash in-flight responses.

## Interface
- DEPTH, 4: queue entries and maximum outstanding requests; power of two, ≥2.
- RESET_PC, 32'h00000000: first fetch address after reset.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  jump or taken branch this cycle.
- redirect_addr  in  32  new fetch target; bits [1:0] forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted when imem_req && imem_gnt.
- imem_rvalid  in  1  one response per grant, in order, ≥1 cycle after grant.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  queue head valid.
- id_ready  in  1  decode accepts head.
- id_instr  out  32  head instruction; 32'h00000013 (NOP) when id_valid=0.
- id_pc  out  32  head PC; 0 when id_valid=0.
- id_pc_plus4  out  32  id_pc + 4 (modulo 2^32), feeds pc_mux increment input.

## Operation
- Registers: fetch_addr, outstanding (0..DEPTH), discard_cnt (0..DEPTH), queue count.
- States: FETCH (discard_cnt=0), FLUSH (discard_cnt>0). FETCH→FLUSH on redirect with nonzero outstanding-after-update; FLUSH→FETCH when last discarded rvalid arrives.
- Credit: imem_req = !redirect_valid && (outstanding + count < DEPTH); id_ready not used in credit check (no combinational ready→req path).
- imem_addr = fetch_addr; on grant fetch_addr += 4 (wraps at 2^32).
- outstanding +1 on grant, −1 on rvalid, both same cycle → unchanged.
- rvalid in FETCH: push {pc, rdata} into queue; pc tracked by a response-address register advancing +4 per accepted response.
- rvalid in FLUSH: data dropped, discard_cnt −1; new requests still allowed.
- Pop on id_valid && id_ready.
- Redirect: queue cleared, fetch_addr ← redirect_addr & ~3, response-address ← same, discard_cnt ← outstanding as updated this cycle (grant this cycle counts, rvalid this cycle is dropped). Redirect wins over simultaneous pop and rvalid. Redirect during FLUSH reloads discard_cnt the same way.
- Queue never overflows: credit guarantees a slot for every outstanding response.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, id_valid 0, id_instr NOP, id_pc 0, id_pc_plus4 4; state FETCH, all counters 0.
- First cycle after reset_n rises: imem_req=1, imem_addr=RESET_PC.
- Latency: grant at t, rvalid at t+1, id_valid at t+2.
- Sustained 1 instr/cycle with single-cycle memory requires DEPTH ≥3.
- Redirect at t: imem_req=0 at t; request to redirect_addr at t+1; earliest id_valid at t+3.
- reset_n asserted mid-operation: all state cleared immediately; responses arriving after release are not expected (memory reset together).

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (32, count of pops) and perf_discarded (32, count of squashed responses plus flushed queue entries), both reset 0, wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package fetch_pkg: NOP_INSTR constant, default RESET_PC, typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, DEPTH entries, push/pop/flush, count output; flush dominates push and pop.

## Test plan
- Reset release, memory grants every cycle, rvalid next cycle, id_ready=1 → id_pc 0x0,0x4,0x8… one per cycle from cycle 2.
- id_ready=0 for 10 cycles → exactly DEPTH requests issued, then imem_req=0; on id_ready=1 drains in order, no loss.
- Redirect to 0x100 with 2 outstanding → both responses dropped, next id_pc=0x100, perf_discarded +2.
- Redirect same cycle as grant and rvalid → granted response also squashed; fetch continues at target with no duplicate.
- redirect_addr=0x203 → imem_addr 0x200.
- imem_gnt held low 5 cycles → imem_req stays 1, imem_addr stable, id_valid remains 0.
